// File: rtl/bounded_updown_counter_pkg.sv
// Shared definitions for the bounded up/down counter.
//   MODE_SAT / MODE_WRAP : meaning of the mode input
//   DIR_DOWN / DIR_UP    : direction code fed to the bound_step block
//   params_ok()          : legality check of the counter parameters, used at
//                          elaboration time by the top level
package bounded_updown_counter_pkg;

  localparam logic MODE_SAT  = 1'b0;
  localparam logic MODE_WRAP = 1'b1;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  // True when the parameter set describes a usable counter:
  // 2..16 bits, MIN < MAX < 2**WIDTH, 1 <= STEP <= range, RESET_VAL in range.
  function automatic bit params_ok(input int width, input int min_v,
                                   input int max_v, input int step,
                                   input int reset_val);
    bit ok;
    ok = (width >= 2) && (width <= 16);
    ok = ok && (min_v >= 0) && (min_v < max_v);
    ok = ok && (max_v < (1 << width));
    ok = ok && (step >= 1) && (step <= (max_v - min_v + 1));
    ok = ok && (reset_val >= min_v) && (reset_val <= max_v);
    return ok;
  endfunction

endpackage

// File: rtl/bounded_updown_counter_if.sv
// Signal bundle of the bounded up/down counter (everything except CLK/Reset).
//   positive, negative : count request, up / down by STEP
//   freeze             : hold the count (does not block load)
//   mode               : MODE_SAT or MODE_WRAP
//   load, load_val     : synchronous load, value clamped into [MIN,MAX]
//   Q                  : registered count
//   Top, Bottom        : Q == MAX, Q == MIN (combinational)
//   carry, borrow      : one-cycle pulses after an up-wrap / down-wrap
// Modports: master drives the controls, slave is the counter.
interface bounded_updown_counter_if #(
  parameter int WIDTH = 4
);
  import bounded_updown_counter_pkg::*;

  logic             positive;
  logic             negative;
  logic             freeze;
  logic             mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] Q;
  logic             Top;
  logic             Bottom;
  logic             carry;
  logic             borrow;

  modport master (
    output positive, negative, freeze, mode, load, load_val,
    input  Q, Top, Bottom, carry, borrow
  );

  modport slave (
    input  positive, negative, freeze, mode, load, load_val,
    output Q, Top, Bottom, carry, borrow
  );

endinterface

// File: rtl/bounded_updown_counter_bound_step.sv
// One bounded step of the counter, purely combinational.
//   q      : current count (assumed inside [MIN,MAX])
//   dir    : DIR_UP adds STEP, DIR_DOWN subtracts STEP
//   mode   : MODE_SAT clamps at the bound, MODE_WRAP wraps around it
//   next_q : resulting count
//   wrap   : high when the step crossed a bound in wrap mode
module bounded_updown_counter_bound_step
  import bounded_updown_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MIN   = 0,
  parameter int MAX   = 9,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] q,
  input  logic             dir,
  input  logic             mode,
  output logic [WIDTH-1:0] next_q,
  output logic             wrap
);

  // Bound comparisons use one extra bit so q + STEP and MIN + STEP never
  // overflow; the results themselves fit in WIDTH bits, so the result
  // arithmetic is done modulo 2**WIDTH.
  localparam logic [WIDTH:0]   MIN_X  = (WIDTH+1)'(MIN);
  localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] low_lim;

  always_comb begin
    sum     = {1'b0, q} + STEP_X;
    low_lim = MIN_X + STEP_X;
    next_q  = q;
    wrap    = 1'b0;
    if (dir == DIR_UP) begin
      if (sum <= MAX_X) begin
        next_q = sum[WIDTH-1:0];
      end else if (mode == MODE_WRAP) begin
        // overshoot past MAX re-enters at MIN
        next_q = MIN_W + (sum[WIDTH-1:0] - MAX_W - ONE_W);
        wrap   = 1'b1;
      end else begin
        next_q = MAX_W;
      end
    end else begin
      // q < MIN + STEP is the underflow test, free of negative values
      if ({1'b0, q} >= low_lim) begin
        next_q = q - STEP_W;
      end else if (mode == MODE_WRAP) begin
        next_q = MAX_W - (low_lim[WIDTH-1:0] - q - ONE_W);
        wrap   = 1'b1;
      end else begin
        next_q = MIN_W;
      end
    end
  end

endmodule

// File: rtl/bounded_updown_counter.sv
// Bounded up/down counter with programmable bounds, step and saturate/wrap
// mode, synchronous load and cascadable carry/borrow pulses.
//   CLK   : clock, all state changes on the rising edge
//   Reset : synchronous active-high reset (Q = RESET_VAL, pulses cleared)
//   bus   : slave side of bounded_updown_counter_if (controls in, Q, Top,
//           Bottom, carry, borrow out)
// Edge priority: Reset > range recovery > load > freeze > both directions
// > up > down > hold.
module bounded_updown_counter
  import bounded_updown_counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MIN       = 0,
  parameter int MAX       = 9,
  parameter int STEP      = 1,
  parameter int RESET_VAL = 0
) (
  input logic                     CLK,
  input logic                     Reset,
  bounded_updown_counter_if.slave bus
);

  generate
    if (!params_ok(WIDTH, MIN, MAX, STEP, RESET_VAL)) begin : g_bad_params
      $error("bounded_updown_counter: illegal WIDTH/MIN/MAX/STEP/RESET_VAL");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] SPAN_W  = WIDTH'(MAX - MIN);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q_r;
  logic             carry_r;
  logic             borrow_r;
  logic [WIDTH-1:0] step_q;
  logic             step_wrap;
  logic             dir;
  logic             in_range;
  logic [WIDTH-1:0] load_clamped;

  // Direction only matters when exactly one of positive/negative is high.
  assign dir = bus.positive ? DIR_UP : DIR_DOWN;

  // Offset from MIN taken modulo 2**WIDTH: a value below MIN wraps to a
  // large offset, so one compare covers both sides of the range.
  assign in_range = ((q_r - MIN_W) <= SPAN_W);

  always_comb begin
    load_clamped = bus.load_val;
    if ((bus.load_val - MIN_W) > SPAN_W) begin
      load_clamped = (bus.load_val > MAX_W) ? MAX_W : MIN_W;
    end
  end

  bounded_updown_counter_bound_step #(
    .WIDTH (WIDTH),
    .MIN   (MIN),
    .MAX   (MAX),
    .STEP  (STEP)
  ) u_bound_step (
    .q      (q_r),
    .dir    (dir),
    .mode   (bus.mode),
    .next_q (step_q),
    .wrap   (step_wrap)
  );

  always_ff @(posedge CLK) begin
    // pulses last exactly one cycle unless a wrap happens on this edge
    carry_r  <= 1'b0;
    borrow_r <= 1'b0;
    if (Reset) begin
      q_r <= RESET_W;
    end else if (!in_range) begin
      q_r <= MIN_W;
    end else if (bus.load) begin
      q_r <= load_clamped;
    end else if (bus.freeze) begin
      q_r <= q_r;
    end else if (bus.positive && bus.negative) begin
      q_r <= q_r;
    end else if (bus.positive || bus.negative) begin
      q_r      <= step_q;
      carry_r  <= step_wrap && (dir == DIR_UP);
      borrow_r <= step_wrap && (dir == DIR_DOWN);
    end
  end

  assign bus.Q      = q_r;
  assign bus.Top    = (q_r == MAX_W);
  assign bus.Bottom = (q_r == MIN_W);
  assign bus.carry  = carry_r;
  assign bus.borrow = borrow_r;

endmodule

// File: tb/tb_bounded_updown_counter.sv
// Bench for bounded_updown_counter: two instances (default 0..9 step 1 and
// 2..13 step 3), directed scenarios followed by random stimulus, every cycle
// compared against a behavioural model using modular range arithmetic.
module tb_bounded_updown_counter;

  typedef struct {
    int min;
    int max;
    int step;
    int rst;
  } cfg_t;

  typedef struct {
    int q;
    bit c;
    bit b;
  } st_t;

  typedef struct {
    bit reset;
    bit load;
    bit freeze;
    bit pos;
    bit neg;
    bit mode;
    int lv;
  } in_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  bounded_updown_counter_if #(.WIDTH(4)) bus_a ();
  bounded_updown_counter_if #(.WIDTH(4)) bus_b ();

  bounded_updown_counter #(
    .WIDTH(4), .MIN(0), .MAX(9), .STEP(1), .RESET_VAL(0)
  ) dut_a (
    .CLK   (clk),
    .Reset (rst_a),
    .bus   (bus_a)
  );

  bounded_updown_counter #(
    .WIDTH(4), .MIN(2), .MAX(13), .STEP(3), .RESET_VAL(2)
  ) dut_b (
    .CLK   (clk),
    .Reset (rst_b),
    .bus   (bus_b)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  cfg_t cfg_a;
  cfg_t cfg_b;
  st_t  st_a;
  st_t  st_b;
  in_t  in_a;
  in_t  in_b;

  logic [3:0] exp_q[$];

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic st_t model_next(input cfg_t c, input st_t s, input in_t i);
    st_t n;
    int  range;
    range = c.max - c.min + 1;
    n.q = s.q;
    n.c = 1'b0;
    n.b = 1'b0;
    if (i.reset) begin
      n.q = c.rst;
    end else if (s.q > c.max || s.q < c.min) begin
      n.q = c.min;
    end else if (i.load) begin
      n.q = (i.lv > c.max) ? c.max : ((i.lv < c.min) ? c.min : i.lv);
    end else if (i.freeze || (i.pos && i.neg)) begin
      n.q = s.q;
    end else if (i.pos) begin
      if (s.q + c.step > c.max) begin
        if (i.mode) begin
          n.q = c.min + (s.q - c.min + c.step) % range;
          n.c = 1'b1;
        end else begin
          n.q = c.max;
        end
      end else begin
        n.q = s.q + c.step;
      end
    end else if (i.neg) begin
      if (s.q - c.step < c.min) begin
        if (i.mode) begin
          n.q = c.min + ((s.q - c.min - c.step) % range + range) % range;
          n.b = 1'b1;
        end else begin
          n.q = c.min;
        end
      end else begin
        n.q = s.q - c.step;
      end
    end
    return n;
  endfunction

  // ---------------- driver tasks ----------------
  function automatic in_t idle();
    in_t i;
    i.reset  = 1'b0;
    i.load   = 1'b0;
    i.freeze = 1'b0;
    i.pos    = 1'b0;
    i.neg    = 1'b0;
    i.mode   = 1'b0;
    i.lv     = 0;
    return i;
  endfunction

  function automatic in_t rand_in();
    in_t i;
    i.reset  = ($urandom_range(0, 39) == 0);
    i.load   = ($urandom_range(0, 7) == 0);
    i.freeze = ($urandom_range(0, 7) == 0);
    i.pos    = 1'($urandom_range(0, 1));
    i.neg    = 1'($urandom_range(0, 1));
    i.mode   = 1'($urandom_range(0, 1));
    i.lv     = int'($urandom_range(0, 15));
    return i;
  endfunction

  task automatic apply();
    rst_a          = in_a.reset;
    bus_a.load     = in_a.load;
    bus_a.freeze   = in_a.freeze;
    bus_a.positive = in_a.pos;
    bus_a.negative = in_a.neg;
    bus_a.mode     = in_a.mode;
    bus_a.load_val = 4'(in_a.lv);
    rst_b          = in_b.reset;
    bus_b.load     = in_b.load;
    bus_b.freeze   = in_b.freeze;
    bus_b.positive = in_b.pos;
    bus_b.negative = in_b.neg;
    bus_b.mode     = in_b.mode;
    bus_b.load_val = 4'(in_b.lv);
  endtask

  // Drive the current inputs, advance one edge, compare both instances.
  task automatic tick();
    apply();
    st_a = model_next(cfg_a, st_a, in_a);
    st_b = model_next(cfg_b, st_b, in_b);
    @(posedge clk);
    #1;
    check("a.Q",      int'(bus_a.Q),      st_a.q);
    check("a.top",    int'(bus_a.Top),    int'(st_a.q == cfg_a.max));
    check("a.bottom", int'(bus_a.Bottom), int'(st_a.q == cfg_a.min));
    check("a.carry",  int'(bus_a.carry),  int'(st_a.c));
    check("a.borrow", int'(bus_a.borrow), int'(st_a.b));
    check("b.Q",      int'(bus_b.Q),      st_b.q);
    check("b.top",    int'(bus_b.Top),    int'(st_b.q == cfg_b.max));
    check("b.bottom", int'(bus_b.Bottom), int'(st_b.q == cfg_b.min));
    check("b.carry",  int'(bus_b.carry),  int'(st_b.c));
    check("b.borrow", int'(bus_b.borrow), int'(st_b.b));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cfg_a = '{min: 0, max: 9,  step: 1, rst: 0};
    cfg_b = '{min: 2, max: 13, step: 3, rst: 2};
    st_a  = '{q: 0, c: 1'b0, b: 1'b0};
    st_b  = '{q: 0, c: 1'b0, b: 1'b0};

    // reset state
    in_a = idle(); in_a.reset = 1'b1;
    in_b = idle(); in_b.reset = 1'b1;
    tick();
    check("rst.a.Q", int'(bus_a.Q), 0);
    check("rst.b.Q", int'(bus_b.Q), 2);
    in_b = idle();

    // wrap counting 1..9,0,1,2 with carry after 9->0
    for (int k = 1; k <= 12; k++) exp_q.push_back(4'(k % 10));
    in_a = idle(); in_a.mode = 1'b1; in_a.pos = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("seq.Q", int'(bus_a.Q), int'(exp_q.pop_front()));
      check("seq.carry", int'(bus_a.carry), int'(k == 10));
    end

    // saturate at both bounds
    in_a = idle(); in_a.load = 1'b1; in_a.lv = 9;
    tick();
    in_a = idle(); in_a.pos = 1'b1;
    tick();
    tick();
    check("sat.top", int'(bus_a.Top), 1);
    in_a = idle(); in_a.load = 1'b1; in_a.lv = 0;
    tick();
    in_a = idle(); in_a.neg = 1'b1;
    tick();
    tick();
    check("sat.bottom", int'(bus_a.Bottom), 1);

    // step 3 wrap on the 2..13 instance
    in_a = idle();
    in_b = idle(); in_b.mode = 1'b1; in_b.load = 1'b1; in_b.lv = 12;
    tick();
    in_b = idle(); in_b.mode = 1'b1; in_b.pos = 1'b1;
    tick();
    check("b.upwrap.Q", int'(bus_b.Q), 3);
    check("b.upwrap.carry", int'(bus_b.carry), 1);
    in_b = idle(); in_b.mode = 1'b1; in_b.neg = 1'b1;
    tick();
    check("b.dnwrap.Q", int'(bus_b.Q), 12);
    check("b.dnwrap.borrow", int'(bus_b.borrow), 1);
    in_b = idle();

    // load clamping and load-over-freeze
    in_a = idle(); in_a.load = 1'b1; in_a.lv = 15;
    tick();
    check("clamp.Q", int'(bus_a.Q), 9);
    in_a = idle(); in_a.load = 1'b1; in_a.freeze = 1'b1; in_a.lv = 4;
    tick();
    check("loadfrz.Q", int'(bus_a.Q), 4);
    in_a = idle(); in_a.freeze = 1'b1; in_a.pos = 1'b1;
    tick();
    check("frz.Q", int'(bus_a.Q), 4);

    // both directions hold, then reset beats load and count
    in_a = idle(); in_a.load = 1'b1; in_a.lv = 5;
    tick();
    in_a = idle(); in_a.pos = 1'b1; in_a.neg = 1'b1; in_a.mode = 1'b1;
    tick();
    check("both.Q", int'(bus_a.Q), 5);
    in_a = idle(); in_a.reset = 1'b1; in_a.load = 1'b1; in_a.lv = 7; in_a.pos = 1'b1;
    tick();
    check("rstprio.Q", int'(bus_a.Q), 0);

    // reset right after a wrap clears the carry pulse
    in_a = idle(); in_a.load = 1'b1; in_a.lv = 9;
    tick();
    in_a = idle(); in_a.mode = 1'b1; in_a.pos = 1'b1;
    tick();
    check("wrap.carry", int'(bus_a.carry), 1);
    in_a.reset = 1'b1;
    tick();
    check("rstclr.carry", int'(bus_a.carry), 0);

    // random traffic on both instances
    for (int n = 0; n < 500; n++) begin
      in_a = rand_in();
      in_b = rand_in();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
